// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_ack;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;
    logic              busy;

    // Arbiter side: requests and memory read data in, everything else out.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output core_rdata, core_ack, ld_rdata, ld_ack,
        output mem_addr, mem_wdata, mem_we, owner, busy
    );

    // Environment side: the two requesters plus the memory device.
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  core_rdata, core_ack, ld_rdata, ld_ack,
        input  mem_addr, mem_wdata, mem_we, owner, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin core/loader arbiter for the unified memory
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t            state_q,      state_d;
    logic [3:0]        cnt_q,        cnt_d;
    logic              we_q,         we_d;
    logic              owner_q,      owner_d;
    logic              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              mem_we_q,     mem_we_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] ld_rdata_q,   ld_rdata_d;
    logic              core_ack_q,   core_ack_d;
    logic              ld_ack_q,     ld_ack_d;
    logic              busy_q,       busy_d;

    logic              grant_ld;

    // Loader wins when it is alone, or when both ask and the core was served last.
    assign grant_ld = bus.ld_req && !(bus.core_req && last_owner_q);

    // Next-state logic: grant in IDLE, count wait states in ACCESS, pulse ack in ACK.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        core_rdata_d = core_rdata_q;
        ld_rdata_d   = ld_rdata_q;
        core_ack_d   = 1'b0;
        ld_ack_d     = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.core_req || bus.ld_req) begin
                    owner_d      = grant_ld;
                    last_owner_d = grant_ld;
                    mem_addr_d   = grant_ld ? bus.ld_addr  : bus.core_addr;
                    mem_wdata_d  = grant_ld ? bus.ld_wdata : bus.core_wdata;
                    we_d         = grant_ld ? bus.ld_we    : bus.core_we;
                    // The write strobe exists only in the first ACCESS cycle.
                    mem_we_d     = grant_ld ? bus.ld_we    : bus.core_we;
                    cnt_d        = CNT_INIT;
                    busy_d       = 1'b1;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        if (owner_q) ld_rdata_d   = bus.mem_rdata;
                        else         core_rdata_d = bus.mem_rdata;
                    end
                    core_ack_d = !owner_q;
                    ld_ack_d   = owner_q;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            core_rdata_q <= '0;
            ld_rdata_q   <= '0;
            core_ack_q   <= 1'b0;
            ld_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            core_rdata_q <= core_rdata_d;
            ld_rdata_q   <= ld_rdata_d;
            core_ack_q   <= core_ack_d;
            ld_ack_q     <= ld_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.core_rdata = core_rdata_q;
    assign bus.core_ack   = core_ack_q;
    assign bus.ld_rdata   = ld_rdata_q;
    assign bus.ld_ack     = ld_ack_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int LAT2 = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if2 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    // Preload pattern of the memory device for never-written words.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        if (a == 32'h40) return 32'hA5A5A5A5;
        return {a[15:0], 16'h5A00} ^ 32'h0F0F_3C3C;
    endfunction

    // Memory device behind the MEM_LAT=2 instance.
    logic [31:0] dev_val [32];
    bit          dev_wr  [32];
    always @(posedge clk) begin
        if (if2.mem_we) begin
            dev_val[if2.mem_addr[6:2]] <= if2.mem_wdata;
            dev_wr[if2.mem_addr[6:2]]  <= 1'b1;
        end
    end
    assign if2.mem_rdata = dev_wr[if2.mem_addr[6:2]] ? dev_val[if2.mem_addr[6:2]]
                                                    : dflt(if2.mem_addr);
    assign if1.mem_rdata = dflt(if1.mem_addr);

    // Reference model: memory contents as last written, per-port read results, round-robin history.
    logic [31:0] ref_val [32];
    bit          ref_wr  [32];
    logic [31:0] ref_core;
    logic [31:0] ref_ld;
    bit          last_owner_m;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_wr[a[6:2]] ? ref_val[a[6:2]] : dflt(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_core     = '0;
        ref_ld       = '0;
        last_owner_m = 1'b1;
    endtask

    task automatic drive(input bit p, input bit req, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            if2.ld_req = req; if2.ld_we = we; if2.ld_addr = a; if2.ld_wdata = d;
        end else begin
            if2.core_req = req; if2.core_we = we; if2.core_addr = a; if2.core_wdata = d;
        end
    endtask

    // Called in the IDLE cycle that samples the request; returns in the ack cycle.
    task automatic follow(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        check("idle_busy", if2.busy, 0);
        check("idle_acks", {if2.core_ack, if2.ld_ack}, 0);
        for (int k = 1; k <= LAT2 + 1; k++) begin
            @(negedge clk);
            check("busy", if2.busy, 1);
            check("owner", if2.owner, p);
            check("mem_we", if2.mem_we, (we && k == 1));
            if (k <= LAT2) begin
                check("mem_addr", if2.mem_addr, a);
                check("mem_wdata", if2.mem_wdata, d);
            end
            check("core_ack", if2.core_ack, (!p && k == LAT2 + 1));
            check("ld_ack", if2.ld_ack, (p && k == LAT2 + 1));
        end
        if (we) begin
            ref_val[a[6:2]] = d;
            ref_wr[a[6:2]]  = 1'b1;
        end else if (p) begin
            ref_ld = ref_read(a);
        end else begin
            ref_core = ref_read(a);
        end
        last_owner_m = p;
        check("core_rdata", if2.core_rdata, ref_core);
        check("ld_rdata", if2.ld_rdata, ref_ld);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
        drive(p, 1'b1, we, a, d);
        follow(p, we, a, d);
        next_cycle();
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        bit          wer [2];
        logic [31:0] ar  [2];
        logic [31:0] dr  [2];
        bit          w;

        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        if1.core_req = 1'b0; if1.core_we = 1'b0; if1.core_addr = '0; if1.core_wdata = '0;
        if1.ld_req = 1'b0;   if1.ld_we = 1'b0;   if1.ld_addr = '0;   if1.ld_wdata = '0;
        model_reset();
        for (int i = 0; i < 32; i++) ref_wr[i] = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("rst_outs2", {if2.core_rdata, if2.ld_rdata}, 0);
        check("rst_bus2", {if2.mem_addr, if2.mem_wdata}, 0);
        check("rst_ctl2", {if2.core_ack, if2.ld_ack, if2.mem_we, if2.owner, if2.busy}, 0);
        check("rst_ctl1", {if1.core_ack, if1.ld_ack, if1.mem_we, if1.owner, if1.busy}, 0);
        next_cycle();

        // Core read of preloaded word
        single(1'b0, 1'b0, 32'h10, 32'h0);
        check("t1_rdata", if2.core_rdata, 32'hDEADBEEF);
        // Loader write
        single(1'b1, 1'b1, 32'h20, 32'h12345678);
        // Back-to-back core reads with req held through the first ack
        drive(1'b0, 1'b1, 1'b0, 32'h00, 32'h0);
        follow(1'b0, 1'b0, 32'h00, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'h04, 32'h0);
        follow(1'b0, 1'b0, 32'h04, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        // Readback of the loader write through the core port
        single(1'b0, 1'b0, 32'h20, 32'h0);
        check("t2_readback", if2.core_rdata, 32'h12345678);

        // Contention right after reset, both requests held: core, loader, core, loader
        reset_pulse();
        drive(1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h18, 32'h0);
        for (int i = 0; i < 4; i++) begin
            follow(i[0], 1'b0, i[0] ? 32'h18 : 32'h14, 32'h0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        next_cycle();

        // Reset in the second ACCESS cycle of a core write
        drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
        next_cycle();
        @(negedge clk);
        check("t5_we_first", if2.mem_we, 1);
        next_cycle();
        #2;
        reset = 1'b0;
        #1;
        check("t5_async", {if2.mem_we, if2.busy, if2.core_ack, if2.ld_ack}, 0);
        @(negedge clk);
        check("t5_in_rst", {if2.mem_we, if2.busy, if2.core_ack, if2.ld_ack}, 0);
        next_cycle();
        reset = 1'b1;
        model_reset();
        follow(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);

        // MEM_LAT=1 instance: loader read of 0x40
        if1.ld_req = 1'b1; if1.ld_addr = 32'h40;
        @(negedge clk);
        check("l1_idle", {if1.busy, if1.ld_ack}, 0);
        @(negedge clk);
        check("l1_access", {if1.busy, if1.ld_ack}, 2'b10);
        @(negedge clk);
        check("l1_ack", {if1.busy, if1.ld_ack, if1.core_ack}, 3'b110);
        check("l1_rdata", if1.ld_rdata, 32'hA5A5A5A5);
        next_cycle();
        if1.ld_req = 1'b0;
        @(negedge clk);
        check("l1_done", {if1.busy, if1.ld_ack}, 0);
        next_cycle();

        // Randomized singles and contention pairs on the MEM_LAT=2 instance
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 2; p++) begin
                wer[p] = 1'($urandom_range(0, 1));
                ar[p]  = 32'($urandom_range(0, 31)) << 2;
                dr[p]  = $urandom;
            end
            if ($urandom_range(0, 3) != 0) begin
                w = 1'($urandom_range(0, 1));
                single(w, wer[w], ar[w], dr[w]);
            end else begin
                drive(1'b0, 1'b1, wer[0], ar[0], dr[0]);
                drive(1'b1, 1'b1, wer[1], ar[1], dr[1]);
                w = !last_owner_m;
                follow(w, wer[w], ar[w], dr[w]);
                next_cycle();
                drive(w, 1'b0, 1'b0, '0, '0);
                follow(!w, wer[!w], ar[!w], dr[!w]);
                next_cycle();
                drive(!w, 1'b0, 1'b0, '0, '0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
